audio_pwm_output: RTL and testbench
===================================

# audio_pwm_output

Downstream consumer of the 16 kHz BRAM sample player. It takes 8-bit offset-binary samples qualified by `sample_tick` and applies a 4-bit volume plus a click-free soft enable/disable gain ramp. It drives the board's mono PWM audio pin and the amplifier shutdown pin. It is the last stage before the audio jack.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: system clock rate. Informational; the PWM period is fixed at 256 clocks.
- `RAMP_STEP_SAMPLES`, default 64: number of sample ticks per ramp gain step.
- `CLK`  in  1  system clock.
- `RESET_N`  in  1  reset, asynchronous, active-low.
- `sample_in`  in  8  unsigned offset-binary sample; 128 = silence. Valid only on cycles where `sample_tick`=1.
- `sample_tick`  in  1  one-cycle strobe, 16 kHz nominal.
- `enable`  in  1  level; 1 = play, 0 = ramp down and shut down.
- `volume`  in  4  user gain, 0..15.
- `aud_pwm`  out  1  PWM audio output.
- `aud_sd`  out  1  amplifier enable; 1 = amplifier on.
- `active`  out  1  high only in state PLAY.

## Operation
- **Datapath:**
  - `s` = `sample_in` − 128, as a 9-bit signed value.
  - `g` = min(`volume`, `ramp_gain`), range 0..15.
  - `p` = `s` × `g`, 13-bit signed.
  - `scaled` = `p` >>> 4 (arithmetic shift; floors toward −inf).
  - `duty` = `scaled` + 128, 8-bit. Range is 8..247, so no saturation logic is needed.
- **PWM:**
  - Free-running 8-bit counter `pwm_cnt` wraps 255→0.
  - `aud_pwm` = (`pwm_cnt` < `duty_reg`), registered.
  - `duty_reg` loads `pending_duty` only on the cycle `pwm_cnt`==255, so every period uses a single duty value.
- **Ramp FSM** (`ramp_gain` 4-bit; step counter counts `sample_tick`s):
  - OFF: `aud_sd`=0, `ramp_gain`=0, `pending_duty` forced to 128. If `enable`=1, go to RAMP_UP.
  - RAMP_UP: `aud_sd`=1. Every `RAMP_STEP_SAMPLES` ticks, `ramp_gain`++. When it reaches 15, go to PLAY. If `enable`=0, go to RAMP_DOWN (gain is held, not reset).
  - PLAY: `aud_sd`=1, `active`=1. If `enable`=0, go to RAMP_DOWN.
  - RAMP_DOWN: `aud_sd`=1. Every `RAMP_STEP_SAMPLES` ticks, `ramp_gain`−−. When it reaches 0, go to OFF. If `enable`=1, go to RAMP_UP from the current gain.
  - The step counter clears on every state change.
- A gain change affects only samples captured after the change. `volume` is sampled together with `sample_in`.
- With no `sample_tick` arriving, `pending_duty` holds its last value; the output holds and does not run away.

## Timing
- **Reset values:** `aud_pwm`=0, `aud_sd`=0, `active`=0, state OFF, `ramp_gain`=0, `pwm_cnt`=0, `duty_reg`=`pending_duty`=128, step counter 0.
- **Pipeline:**
  - Tick at edge T: sample and volume captured.
  - Edge T+1: product registered.
  - Edge T+2: `pending_duty` valid.
  - The value reaches `duty_reg` at the next `pwm_cnt`==255 edge. Worst-case latency is 258 clocks.
- **Simultaneous events:**
  - `pending_duty` write on the same edge as the `duty_reg` load: `duty_reg` takes the old `pending_duty`.
  - Ramp step and sample capture on the same tick: the capture uses the pre-step gain.
- **Timing relations:**
  - `aud_sd` rises on the same edge as the OFF→RAMP_UP transition.
  - `aud_sd` falls on the RAMP_DOWN→OFF edge.
  - `active` is registered from state, so it changes one clock after the state transition.
- **Mid-operation reset:** asserting `RESET_N` low in any state immediately forces the reset values above (asynchronous). `aud_sd` drops without a ramp.

## Structure
- Package `audio_pkg`:
  - `SILENCE` = 8'd128
  - `GAIN_MAX` = 4'd15
  - `ramp_state_t` enum {OFF, RAMP_UP, PLAY, RAMP_DOWN}
- Sub-module `audio_pwm_core` contains `pwm_cnt`, the `duty_reg` boundary load and the compare.
  - Ports: `CLK`, `RESET_N`, `pending_duty`[7:0], `aud_pwm`.
- The FSM and datapath live in the top level.

## Test plan
1. **Reset:** hold `RESET_N`=0 with `enable`=1 → all outputs 0. After release, `aud_sd` rises after one clock; `aud_pwm` duty is 128/256 while gain is 0.
2. **Full-scale gain:** `RAMP_STEP_SAMPLES`=2, `volume`=15, constant `sample_in`=255 →
   - `ramp_gain` reaches 15 after 30 ticks; `active` goes high.
   - Measured high time is then 247 of 256 clocks.
   - With `sample_in`=0, high time is 8.
3. **Zero volume:** `volume`=0 in PLAY, `sample_in`=200 → duty stays 128. Then `volume`=8 → duty = 128 + ((72×8)>>>4) = 164.
4. **Disable mid-ramp:** drop `enable` when `ramp_gain`=5 in RAMP_UP → state goes to RAMP_DOWN, gain decrements 5→0, then state OFF and `aud_sd`=0. Re-raising `enable` at gain 3 resumes RAMP_UP from 3.
5. **Boundary-only duty update:** apply `sample_tick` when `pwm_cnt`=100 → `aud_pwm` duty is unchanged until the period after the next `pwm_cnt`=255 edge. A tick landing 2 cycles before the boundary misses that boundary and takes effect one period later.
6. **Async reset in PLAY:** pulse `RESET_N` low for 3 clocks mid-period → `aud_pwm` and `aud_sd` go low within the reset cycle. After release the block restarts from OFF with a full ramp.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, ramp state encoding and the signed-product to PWM duty mapping
package audio_pkg;
  localparam logic [7:0] SILENCE = 8'd128;
  localparam logic [3:0] GAIN_MAX = 4'd15;
  typedef enum logic [1:0] {OFF, RAMP_UP, PLAY, RAMP_DOWN} ramp_state_t;
  function automatic logic [7:0] duty_of(input logic signed [12:0] p);
    logic signed [12:0] scaled;
    scaled = p >>> 4;
    return scaled[7:0] + SILENCE;
  endfunction
endpackage

// File: rtl/audio_pwm_core.sv
// audio_pwm_core: free-running 256-clock PWM whose duty only changes at the period boundary
module audio_pwm_core
  import audio_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] pending_duty,
  output logic       aud_pwm
);
  logic [7:0] pwm_cnt;
  logic [7:0] duty_reg;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt  <= '0;
      duty_reg <= SILENCE;
      aud_pwm  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) duty_reg <= pending_duty;
      aud_pwm <= pwm_cnt < duty_reg;
    end
  end
endmodule

// File: rtl/audio_pwm_output.sv
// audio_pwm_output: volume and click-free soft-ramp gain on 8-bit samples, driving the PWM pin and amp enable
module audio_pwm_output
  import audio_pkg::*;
#(
  parameter int CLK_FREQ_HZ       = 100_000_000,
  parameter int RAMP_STEP_SAMPLES = 64
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] sample_in,
  input  logic       sample_tick,
  input  logic       enable,
  input  logic [3:0] volume,
  output logic       aud_pwm,
  output logic       aud_sd,
  output logic       active
);
  localparam int SW = $clog2(RAMP_STEP_SAMPLES + 1);
  if (CLK_FREQ_HZ <= 0 || RAMP_STEP_SAMPLES <= 0) begin : g_bad_param
    $error("audio_pwm_output: CLK_FREQ_HZ and RAMP_STEP_SAMPLES must be positive");
  end
  ramp_state_t state, state_nxt;
  logic [3:0] ramp_gain, gain_nxt;
  logic [SW-1:0] step_cnt, step_nxt;
  logic step_done;
  assign step_done = sample_tick && step_cnt == SW'(RAMP_STEP_SAMPLES - 1);
  always_comb begin
    state_nxt = state;
    gain_nxt  = ramp_gain;
    case (state)
      OFF: begin
        gain_nxt = '0;
        if (enable) state_nxt = RAMP_UP;
      end
      RAMP_UP:
        if (!enable) state_nxt = RAMP_DOWN;
        else if (ramp_gain == GAIN_MAX) state_nxt = PLAY;
        else if (step_done) begin
          gain_nxt  = ramp_gain + 4'd1;
          state_nxt = (ramp_gain == GAIN_MAX - 4'd1) ? PLAY : RAMP_UP;
        end
      PLAY: if (!enable) state_nxt = RAMP_DOWN;
      RAMP_DOWN:
        if (enable) state_nxt = RAMP_UP;
        else if (ramp_gain == 4'd0) state_nxt = OFF;
        else if (step_done) begin
          gain_nxt  = ramp_gain - 4'd1;
          state_nxt = (ramp_gain == 4'd1) ? OFF : RAMP_DOWN;
        end
      default: state_nxt = OFF;
    endcase
    step_nxt = (state_nxt != state || step_done) ? '0 :
               (sample_tick && (state == RAMP_UP || state == RAMP_DOWN)) ? step_cnt + SW'(1) : step_cnt;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= OFF;
      ramp_gain <= '0;
      step_cnt  <= '0;
      aud_sd    <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ramp_gain <= gain_nxt;
      step_cnt  <= step_nxt;
      aud_sd    <= state_nxt != OFF;
      active    <= state == PLAY;
    end
  end
  // Gain is taken from the pre-step ramp value so a step on the same tick only affects later samples.
  logic signed [8:0]  cap_s;
  logic [3:0]         cap_g;
  logic               cap_v;
  logic signed [12:0] prod;
  logic               prod_v;
  logic [7:0]         pending_duty;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_s        <= '0;
      cap_g        <= '0;
      cap_v        <= 1'b0;
      prod         <= '0;
      prod_v       <= 1'b0;
      pending_duty <= SILENCE;
    end else begin
      cap_v  <= sample_tick;
      prod_v <= cap_v;
      if (sample_tick) begin
        cap_s <= $signed({1'b0, sample_in}) - 9'sd128;
        cap_g <= (volume < ramp_gain) ? volume : ramp_gain;
      end
      prod <= 13'(cap_s) * 13'($signed({1'b0, cap_g}));
      pending_duty <= (state == OFF) ? SILENCE : prod_v ? duty_of(prod) : pending_duty;
    end
  end
  audio_pwm_core u_core (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .pending_duty (pending_duty),
    .aud_pwm      (aud_pwm)
  );
endmodule

// File: tb/tb_audio_pwm_output.sv
// tb_audio_pwm_output: randomized + directed scoreboard bench measuring PWM high time per period
module tb_audio_pwm_output;
  localparam int STEP = 2;
  localparam int S_OFF = 0, S_UP = 1, S_PLAY = 2, S_DOWN = 3;
  logic CLK = 1'b0, RESET_N = 1'b1;
  logic [7:0] sample_in = 8'd128;
  logic sample_tick = 1'b0, enable = 1'b0;
  logic [3:0] volume = 4'd0;
  logic aud_pwm, aud_sd, active;

  audio_pwm_output #(.RAMP_STEP_SAMPLES(STEP)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .sample_in(sample_in), .sample_tick(sample_tick),
    .enable(enable), .volume(volume), .aud_pwm(aud_pwm), .aud_sd(aud_sd), .active(active)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;
  typedef struct {int due; int duty;} pend_t;
  pend_t pipe[$];
  int exp_q[$];
  int m_n, m_pend, m_gain, m_step, m_state;
  logic m_sd, m_act, m_chg;
  int hi, last_meas;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_duty(input int smp, input int vol, input int gain);
    int p, q;
    p = (smp - 128) * (vol < gain ? vol : gain);
    q = p >= 0 ? p / 16 : -((15 - p) / 16);
    return 128 + q;
  endfunction

  // Reference model: spec rules evaluated once per clock edge on the values present before the edge.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_n = 0; m_pend = 128; m_gain = 0; m_step = 0; m_state = S_OFF;
      m_sd = 0; m_act = 0; m_chg = 0;
      pipe.delete(); exp_q.delete(); exp_q.push_back(128);
    end else begin
      int ns, ng, np;
      m_n++;
      if (m_n % 256 == 0) exp_q.push_back(m_pend);
      np = m_pend;
      while (pipe.size() > 0 && pipe[0].due == m_n) begin
        np = pipe[0].duty;
        void'(pipe.pop_front());
      end
      if (m_state == S_OFF) np = 128;
      if (sample_tick) pipe.push_back('{m_n + 2, ref_duty(int'(sample_in), int'(volume), m_gain)});
      ns = m_state; ng = m_gain;
      if (m_state == S_OFF) begin
        if (enable) ns = S_UP;
      end else if (m_state == S_PLAY) begin
        if (!enable) ns = S_DOWN;
      end else if (m_state == S_UP && !enable) ns = S_DOWN;
      else if (m_state == S_DOWN && enable) ns = S_UP;
      else if (m_state == S_UP && m_gain == 15) ns = S_PLAY;
      else if (m_state == S_DOWN && m_gain == 0) ns = S_OFF;
      else begin
        if (sample_tick) m_step++;
        if (m_step == STEP) begin
          m_step = 0;
          ng = m_state == S_UP ? m_gain + 1 : m_gain - 1;
        end
        if (m_state == S_UP && ng == 15) ns = S_PLAY;
        if (m_state == S_DOWN && ng == 0) ns = S_OFF;
      end
      if (ns != m_state) m_step = 0;
      m_chg = ns != m_state;
      m_act = m_state == S_PLAY;
      m_state = ns; m_gain = ng; m_pend = np;
      m_sd = ns != S_OFF;
    end
  end

  // Monitor: sums aud_pwm over each 256-clock period and pops the duty expected for it.
  always @(negedge CLK) begin
    if (!RESET_N) hi = 0;
    else if (m_n > 0) begin
      hi += int'(aud_pwm);
      if (m_n % 256 == 0) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL duty_scoreboard: period ended with no expected duty at %0t", $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("pwm_high_time", hi, e);
        end
        last_meas = hi;
        hi = 0;
      end
      if (m_chg || m_n % 32 == 0) begin
        check("aud_sd", int'(aud_sd), int'(m_sd));
        check("active", int'(active), int'(m_act));
      end
    end
  end

  task automatic tick(input int s, input int gap);
    @(negedge CLK);
    sample_in = s < 0 ? 8'($urandom) : 8'(s);
    sample_tick = 1'b1;
    @(negedge CLK);
    sample_tick = 1'b0;
    sample_in = 8'($urandom);
    repeat (gap) @(negedge CLK);
  endtask

  task automatic ticks_until(input int st, input int gain, input int budget);
    int n;
    n = 0;
    while (!(m_state == st && (gain < 0 || m_gain == gain)) && n < budget) begin
      tick(-1, 3);
      n++;
    end
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_state: state %0d gain %0d, wanted state %0d gain %0d", m_state, m_gain, st, gain);
    end
  endtask

  task automatic wait_boundary();
    do @(negedge CLK); while (m_n % 256 != 0);
    #1;
  endtask

  task automatic count_ramp(input string name);
    int n;
    n = 0;
    while (!active && n < 40) begin
      tick(255, 4);
      n++;
    end
    check(name, n, 30);
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    enable = 1'b1;
    volume = 4'd15;
    repeat (4) @(negedge CLK);
    check("rst_aud_pwm", int'(aud_pwm), 0);
    check("rst_aud_sd", int'(aud_sd), 0);
    check("rst_active", int'(active), 0);
    #2 RESET_N = 1'b1;
    @(negedge CLK);
    check("sd_rise", int'(aud_sd), 1);
    wait_boundary();
    check("gain0_duty", last_meas, 128);
    count_ramp("ticks_to_play");
    repeat (60) tick(255, 15);
    wait_boundary();
    check("full_scale_high", last_meas, 247);
    repeat (60) tick(0, 15);
    wait_boundary();
    check("full_scale_low", last_meas, 8);
    volume = 4'd0;
    repeat (60) tick(200, 15);
    wait_boundary();
    check("zero_volume", last_meas, 128);
    volume = 4'd8;
    repeat (60) tick(200, 15);
    wait_boundary();
    check("volume8", last_meas, 164);
    volume = 4'd15;
    repeat (60) tick(255, 15);
    while (m_n % 256 != 100) @(negedge CLK);
    sample_in = 8'd0;
    sample_tick = 1'b1;
    @(negedge CLK);
    sample_tick = 1'b0;
    wait_boundary();
    check("mid_period_hold", last_meas, 247);
    wait_boundary();
    check("next_period_new", last_meas, 8);
    while (m_n % 256 != 253) @(negedge CLK);
    sample_in = 8'd255;
    sample_tick = 1'b1;
    @(negedge CLK);
    sample_tick = 1'b0;
    wait_boundary();
    check("late_tick_prev", last_meas, 8);
    wait_boundary();
    check("late_tick_missed", last_meas, 8);
    wait_boundary();
    check("late_tick_applied", last_meas, 247);
    enable = 1'b0;
    ticks_until(S_OFF, -1, 60);
    check("sd_off", int'(aud_sd), 0);
    enable = 1'b1;
    ticks_until(S_UP, 5, 40);
    enable = 1'b0;
    @(negedge CLK);
    check("down_active", int'(active), 0);
    check("down_sd", int'(aud_sd), 1);
    ticks_until(S_DOWN, 3, 40);
    enable = 1'b1;
    ticks_until(S_PLAY, -1, 60);
    repeat (2) @(negedge CLK);
    check("resume_active", int'(active), 1);
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) volume = 4'($urandom);
      tick(-1, $urandom_range(1, 40));
    end
    enable = 1'b1;
    volume = 4'd15;
    ticks_until(S_PLAY, -1, 80);
    repeat (100) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("async_aud_pwm", int'(aud_pwm), 0);
    check("async_aud_sd", int'(aud_sd), 0);
    check("async_active", int'(active), 0);
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    count_ramp("ticks_after_reset");
    repeat (40) tick(-1, 10);
    wait_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end
endmodule
